control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch, decode, ALU/LDI/branch/NOP/HALT sequencing with registered Moore strobes.
// Optional branch support is compiled in when the macro CU_BRANCH_EN is defined.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [4:0] opcode,
    input  logic       C,
    input  logic       N,
    input  logic       Z,
    input  logic       P,
    output logic       mdr_alu_n,
    output logic       mdr_en,
    output logic       mar_en,
    output logic       ir_en,
    output logic       ir_clr,
    output logic       bank_wr_en,
    output logic       enaf,
    output logic       wr_rd_n,
    output logic [2:0] BusB_addr,
    output logic [2:0] BusC_addr,
    output logic [2:0] selop,
    output logic [1:0] shamt,
    output logic       halted,
    output logic       instr_done
);

    localparam logic [2:0] REG_ACC   = 3'd0;
    localparam logic [2:0] REG_OPND  = 3'd1;
    localparam logic [2:0] REG_PC    = 3'd7;
    localparam logic [2:0] SEL_PASSB = 3'b110;
    localparam logic [2:0] SEL_INCB  = 3'b111;
    localparam logic [1:0] SH_ONE    = 2'b01;

    typedef enum logic [4:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_F3, S_F4, S_DECODE,
        S_E0, S_E1, S_O0, S_O1, S_O2, S_O3,
        S_LDW, S_BRW, S_NOPD, S_HALT
    } state_t;

    typedef struct packed {
        logic       mdr_alu_n;
        logic       mdr_en;
        logic       mar_en;
        logic       ir_en;
        logic       ir_clr;
        logic       bank_wr_en;
        logic       enaf;
        logic       wr_rd_n;
        logic       instr_done;
        logic       halted;
        logic [2:0] busb;
        logic [2:0] busc;
        logic [2:0] selop;
        logic [1:0] shamt;
    } out_t;

    state_t state_q, state_d;
    out_t   out_q, out_d;
    logic   taken_d;

`ifdef CU_BRANCH_EN
    logic taken_q;
    logic is_br_q, is_br_d;
    logic cond_met;

    always_comb begin
        case (opcode[2:0])
            3'd0:    cond_met = 1'b1;
            3'd1:    cond_met = Z;
            3'd2:    cond_met = N;
            3'd3:    cond_met = C;
            3'd4:    cond_met = P;
            default: cond_met = 1'b0;
        endcase
    end
`else
    logic unused_flags;
    assign unused_flags = ^{C, N, Z, P};
    assign taken_d      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
`ifdef CU_BRANCH_EN
        taken_d = taken_q;
        is_br_d = is_br_q;
`endif
        case (state_q)
            S_IDLE:   if (run) state_d = S_F0;
            S_F0:     state_d = S_F1;
            S_F1:     state_d = S_F2;
            S_F2:     state_d = S_F3;
            S_F3:     state_d = S_F4;
            S_F4:     state_d = S_DECODE;
            S_DECODE: begin
                if (opcode[4:3] == 2'b00) begin
                    state_d = S_E0;
                end else if (opcode == 5'b01000) begin
                    state_d = S_O0;
`ifdef CU_BRANCH_EN
                    is_br_d = 1'b0;
                end else if (opcode[4:3] == 2'b10) begin
                    // Flags are captured here and held until the write-back state.
                    state_d = S_O0;
                    is_br_d = 1'b1;
                    taken_d = cond_met;
`endif
                end else if (opcode == 5'b11111) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_NOPD;
                end
            end
            S_E0:     state_d = S_E1;
            S_O0:     state_d = S_O1;
            S_O1:     state_d = S_O2;
            S_O2:     state_d = S_O3;
`ifdef CU_BRANCH_EN
            S_O3:     state_d = is_br_q ? S_BRW : S_LDW;
`else
            S_O3:     state_d = S_LDW;
`endif
            S_E1, S_LDW, S_BRW, S_NOPD: state_d = S_F0;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copy lines up with state_q.
    always_comb begin
        out_d = '0;
        case (state_d)
            S_IDLE:   out_d.ir_clr = 1'b1;
            S_F0, S_O0: begin
                out_d.busb   = REG_PC;
                out_d.selop  = SEL_PASSB;
                out_d.mdr_en = 1'b1;
            end
            S_F1, S_O1: begin
                out_d.mar_en = 1'b1;
                out_d.busb   = REG_PC;
                out_d.selop  = SEL_INCB;
                out_d.mdr_en = 1'b1;
            end
            S_F2, S_O2: begin
                out_d.bank_wr_en = 1'b1;
                out_d.busc       = REG_PC;
            end
            S_F3, S_O3: begin
                out_d.mdr_alu_n = 1'b1;
                out_d.mdr_en    = 1'b1;
            end
            S_F4:     out_d.ir_en = 1'b1;
            S_E0: begin
                out_d.selop  = opcode[2:0];
                out_d.busb   = REG_OPND;
                out_d.shamt  = SH_ONE;
                out_d.enaf   = 1'b1;
                out_d.mdr_en = 1'b1;
            end
            S_E1, S_LDW: begin
                out_d.bank_wr_en = 1'b1;
                out_d.busc       = REG_ACC;
                out_d.instr_done = 1'b1;
            end
            S_BRW: begin
                out_d.bank_wr_en = taken_d;
                out_d.busc       = taken_d ? REG_PC : REG_ACC;
                out_d.instr_done = 1'b1;
            end
            S_NOPD:   out_d.instr_done = 1'b1;
            S_HALT:   out_d.halted = 1'b1;
            default:  out_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            out_q         <= '0;
            out_q.ir_clr  <= 1'b1;
`ifdef CU_BRANCH_EN
            taken_q       <= 1'b0;
            is_br_q       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
`ifdef CU_BRANCH_EN
            taken_q <= taken_d;
            is_br_q <= is_br_d;
`endif
        end
    end

    assign mdr_alu_n  = out_q.mdr_alu_n;
    assign mdr_en     = out_q.mdr_en;
    assign mar_en     = out_q.mar_en;
    assign ir_en      = out_q.ir_en;
    assign ir_clr     = out_q.ir_clr;
    assign bank_wr_en = out_q.bank_wr_en;
    assign enaf       = out_q.enaf;
    assign wr_rd_n    = out_q.wr_rd_n;
    assign instr_done = out_q.instr_done;
    assign halted     = out_q.halted;
    assign BusB_addr  = out_q.busb;
    assign BusC_addr  = out_q.busc;
    assign selop      = out_q.selop;
    assign shamt      = out_q.shamt;

endmodule
